// File: rtl/hold_counter_pkg.sv
// hold_counter shared types: FSM state encoding and width constants.
// Imported by hold_counter and sat_counter.
package hold_counter_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int DET_W     = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    COUNT    = 3'd2,
    RELEASE  = 3'd3,
    WAIT_LOW = 3'd4
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// 8-bit saturating event counter with async active-low clear.
// Used for the release statistics of hold_counter.
module sat_counter
  import hold_counter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [DET_W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      q <= '0;
    else if (inc && (q != {DET_W{1'b1}}))
      q <= q + 1'b1;
  end

endmodule

// File: rtl/hold_counter.sv
// Hold counter: delays a detector flag, then returns a one-cycle release.
// Optional release statistics under macro HOLD_COUNTER_STATS_EN.
module hold_counter
  import hold_counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w,
  input  logic [WIDTH-1:0] init,
  output logic             en,
  output logic             busy,
  output logic [WIDTH-1:0] cnt,
  output logic [DET_W-1:0] det_cnt
);

  localparam logic [WIDTH-1:0] TOP = '1;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] cnt_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = IDLE;
    cnt_nx   = '0;
    en       = 1'b0;
    busy     = 1'b0;
    case (state)
      IDLE: begin
        if (w) state_nx = LOAD;
      end
      LOAD: begin
        busy     = 1'b1;
        cnt_nx   = init;
        state_nx = COUNT;
      end
      COUNT: begin
        busy = 1'b1;
        if (cnt == TOP) begin
          cnt_nx   = cnt;
          state_nx = RELEASE;
        end else begin
          cnt_nx   = cnt + 1'b1;
          state_nx = COUNT;
        end
      end
      RELEASE: begin
        en       = 1'b1;
        busy     = 1'b1;
        cnt_nx   = cnt;
        state_nx = WAIT_LOW;
      end
      // a flag that never drops parks here instead of retriggering
      WAIT_LOW: begin
        state_nx = w ? WAIT_LOW : IDLE;
      end
      default: ;
    endcase
  end

`ifdef HOLD_COUNTER_STATS_EN
  sat_counter u_stats (
    .clk (clk),
    .rst (rst),
    .inc (state == RELEASE),
    .q   (det_cnt)
  );
`else
  assign det_cnt = '0;
`endif

endmodule

// File: tb/tb_hold_counter.sv
// Directed self-checking bench for hold_counter (WIDTH=4).
// Stats expectations follow HOLD_COUNTER_STATS_EN.
module tb_hold_counter;

  logic       clk;
  logic       rst;
  logic       w;
  logic       w_tb;
  logic [3:0] init;
  logic       en;
  logic       busy;
  logic [3:0] cnt;
  logic [7:0] det_cnt;

  logic       det_on;
  logic       det_w;
  logic       i;
  logic [1:0] h;

  int total = 0;
  int bad   = 0;
  int pulses;
  int lat;
  int dexp;
  logic prev_en;
  logic saw_w;
  logic [6:0] seq;

  assign w = det_on ? det_w : w_tb;

  hold_counter #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .w       (w),
    .init    (init),
    .en      (en),
    .busy    (busy),
    .cnt     (cnt),
    .det_cnt (det_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // upstream detector model: flags three 1s in a row, clears on en
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      det_w <= 1'b0;
      h     <= 2'b00;
    end else begin
      if (en)
        det_w <= 1'b0;
      else if (i && h[1] && h[0])
        det_w <= 1'b1;
      h <= {h[0], i};
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one detection from IDLE; returns edges until en, -1 on timeout
  task automatic run_hold(output int l);
    l = -1;
    w_tb = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (en) begin
        l = k;
        break;
      end
    end
    w_tb = 1'b0;
    tick();
    tick();
  endtask

  function automatic int stats(input int n);
`ifdef HOLD_COUNTER_STATS_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  initial begin
    rst = 1'b0; w_tb = 1'b0; init = 4'd12;
    det_on = 1'b0; i = 1'b0;
    #3;
    chk("rst_cnt", cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_en", en, 0);
    chk("rst_det", det_cnt, 0);
    @(negedge clk);
    rst = 1'b1;

    // init=12: cnt 12..15, en after edge 6, w drop and init change ignored
    w_tb = 1'b1;
    tick();
    chk("load_busy", busy, 1);
    chk("load_en", en, 0);
    for (int k = 2; k <= 5; k++) begin
      tick();
      chk("cnt_seq", cnt, 10 + k);
      chk("cnt_en", en, 0);
      if (k == 3) begin
        w_tb = 1'b0;
        init = 4'd3;
      end
    end
    tick();
    chk("rel_en", en, 1);
    chk("rel_cnt", cnt, 15);
    chk("rel_busy", busy, 1);
    tick();
    chk("wl_en", en, 0);
    chk("wl_busy", busy, 0);
    chk("det1", det_cnt, stats(1));
    tick();
    chk("idle_cnt", cnt, 0);

    // init=15: one COUNT cycle, held w does not retrigger
    init = 4'd15;
    w_tb = 1'b1;
    tick();
    tick();
    chk("i15_cnt", cnt, 15);
    chk("i15_en_e2", en, 0);
    tick();
    chk("i15_en_e3", en, 1);
    chk("i15_rel_cnt", cnt, 15);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (en) pulses++;
    end
    chk("held_pulses", pulses, 0);
    chk("parked_busy", busy, 0);
    w_tb = 1'b0;
    tick();
    w_tb = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (en) pulses++;
    end
    chk("retrig_pulses", pulses, 1);
    chk("det3", det_cnt, stats(3));
    w_tb = 1'b0;
    tick();
    tick();

    // reset while cnt=13
    init = 4'd12;
    w_tb = 1'b1;
    tick();
    tick();
    tick();
    chk("pre_rst_cnt", cnt, 13);
    rst = 1'b0;
    #1;
    chk("arst_cnt", cnt, 0);
    chk("arst_busy", busy, 0);
    chk("arst_en", en, 0);
    chk("arst_det", det_cnt, 0);
    #2;
    rst = 1'b1;
    w_tb = 1'b0;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (en) pulses++;
    end
    chk("post_rst_pulses", pulses, 0);
    chk("post_rst_det", det_cnt, 0);

    // 256 back-to-back detections, det_cnt saturates
    init = 4'd15;
    for (int n = 1; n <= 256; n++) begin
      run_hold(lat);
      if (lat != 3) chk("b2b_lat", lat, 3);
      dexp = (n > 255) ? 255 : n;
      if (n == 1 || n == 254 || n == 255 || n == 256)
        chk("b2b_det", det_cnt, stats(dexp));
    end

    // driven by the detector model: i = 0,1,1,1,1,1,0
    init = 4'd12;
    seq = 7'b0111110;
    det_on = 1'b1;
    pulses = 0;
    prev_en = 1'b0;
    saw_w = 1'b0;
    for (int k = 0; k < 32; k++) begin
      i = (k < 7) ? seq[6-k] : 1'b0;
      tick();
      if (prev_en) chk("det_w_fall", w, 0);
      if (w) saw_w = 1'b1;
      if (en) pulses++;
      prev_en = en;
    end
    chk("det_w_rose", saw_w, 1);
    chk("det_pulses", pulses, 1);
    chk("det_final_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hold_counter.md
HOLD_COUNTER -- requirements
Module: hold_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the bit width of the hold counter.
REQ-002 SHALL have port clk  input  1  rising-edge system clock.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port w  input  1  level flag from the upstream sequence detector; high while a detection is pending.
REQ-005 SHALL have port init  input  WIDTH  counter start value, sampled in LOAD only.
REQ-006 SHALL have port en  output  1  one-cycle release pulse returned to the detector.
REQ-007 SHALL have port busy  output  1  high in LOAD, COUNT and RELEASE.
REQ-008 SHALL have port cnt  output  WIDTH  current hold count.
REQ-009 SHALL have port det_cnt  output  8  number of completed releases.

Function
REQ-010 SHALL implement a Moore FSM with states IDLE, LOAD, COUNT, RELEASE and WAIT_LOW; all outputs are registered or decoded from state only.
REQ-011 IDLE: cnt=0, busy=0, en=0; w=1 -> LOAD; w=0 -> stay in IDLE.
REQ-012 LOAD: cnt <= init, then unconditionally -> COUNT.
REQ-013 COUNT: if cnt = 2^WIDTH-1 -> RELEASE with cnt held; otherwise cnt <= cnt+1 and stay. cnt never wraps.
REQ-014 RELEASE: en=1 for exactly one cycle, cnt holds, det_cnt increments, then -> WAIT_LOW.
REQ-015 WAIT_LOW: en=0, busy=0, cnt <= 0; w=0 -> IDLE; w=1 -> stay. A w level that never drops SHALL NOT retrigger.
REQ-016 Latency: from the first edge sampling w=1 in IDLE, en is high in the cycle after edge number 2^WIDTH - init + 2.
REQ-017 init = 2^WIDTH-1 SHALL spend exactly one cycle in COUNT.
REQ-018 Changes on w during LOAD, COUNT or RELEASE SHALL be ignored, including a w drop.
REQ-019 Changes on init outside LOAD SHALL have no effect.
REQ-020 det_cnt SHALL saturate at 255; a release at 255 leaves it at 255.
REQ-021 Unreachable state encodings SHALL return to IDLE on the next edge.

Reset
REQ-022 When rst=0, asynchronously: state=IDLE, cnt=0, en=0, busy=0, det_cnt=0.
REQ-023 Reset during any state, including mid-COUNT or RELEASE, SHALL abort with no en pulse and no det_cnt increment.
REQ-024 After rst deasserts, the first edge SHALL behave as IDLE.

Configuration
REQ-025 Macro HOLD_COUNTER_STATS_EN: when defined, det_cnt behaves per REQ-014 and REQ-020.
REQ-026 When HOLD_COUNTER_STATS_EN is undefined, det_cnt SHALL be constant 0 and no statistics register is instantiated; all other behaviour is unchanged.

Structure
REQ-027 Package hold_counter_pkg SHALL hold the state typedef/encoding (3 bits), the default WIDTH constant, and the det_cnt width constant (8).
REQ-028 Sub-module sat_counter (8-bit saturating incrementer with inc input and async active-low clear) SHALL implement det_cnt and is instantiated only under HOLD_COUNTER_STATS_EN.

Verification
REQ-029 WIDTH=4, init=12; w rises before edge 1 -> cnt 12,13,14,15; en high only after edge 6; det_cnt=1.
REQ-030 init=15 -> exactly one COUNT cycle; en high after edge 3; cnt=15 during RELEASE.
REQ-031 w held high throughout two full hold periods -> exactly one en pulse, FSM parked in WAIT_LOW; w low for one cycle then high again -> second en pulse.
REQ-032 rst pulsed low while cnt=13 -> cnt=0, busy=0 immediately; no en pulse; det_cnt unchanged at 0.
REQ-033 256 back-to-back detections -> det_cnt reaches 255 and stays at 255; with macro undefined, det_cnt stays 0 throughout.
REQ-034 Connected to the detector, stimulus i = 0,1,1,1,1,1,0 -> w rises, en pulses once after the hold, detector w falls the cycle after en.
